mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/cachepkg.sv | 13 +
 rtl/mem_array.sv | 26 ++
 rtl/mem_responder.sv | 168 ++++++++++++++++
 tb/tb_mem_responder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cachepkg.sv
// Types and default constants shared between the cache and its next-level memory responder.
package cachepkg;
  localparam int LINEITEMS = 4;
  localparam int LATENCY   = 4;

  // One-hot encoding so that any corrupted state word is detectable.
  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    WAIT  = 4'b0010,
    BURST = 4'b0100,
    DONE  = 4'b1000
  } mem_state_t;
endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word store backing the responder; contents power up zeroed and survive reset.
module mem_array #(
  parameter int WORDBITS = 32,
  parameter int DEPTH    = 4096,
  parameter int AW       = 12
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                en,
  input  logic                we,
  input  logic [AW-1:0]       addr,
  input  logic [WORDBITS-1:0] wdata,
  output logic [WORDBITS-1:0] rdata
);
  logic [WORDBITS-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clock) begin
    if (en && we) mem[addr] <= wdata;
  end

  // Only the read register is reset; the storage itself is never cleared.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)           rdata <= '0;
    else if (en && !we)  rdata <= mem[addr];
  end
endmodule

// File: rtl/mem_responder.sv
// Cache-line memory responder: critical-word-first fills and writebacks after a fixed wait.
// Optional MEM_BOUNDS_CHECK_EN adds the error port and out-of-range line rejection.
module mem_responder #(
  parameter int ADDRBITS  = 32,
  parameter int WORDBITS  = 32,
  parameter int LINEITEMS = cachepkg::LINEITEMS,
  parameter int MEMLINES  = 1024,
  parameter int LATENCY   = cachepkg::LATENCY
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                request,
  input  logic                write,
  input  logic [ADDRBITS-1:0] addr,
  input  logic [WORDBITS-1:0] wdata,
  output logic [WORDBITS-1:0] rdata,
  output logic                valid,
  output logic                done,
  output logic                busy
`ifdef MEM_BOUNDS_CHECK_EN
  ,
  output logic                error
`endif
);
  import cachepkg::*;

  localparam int BO  = $clog2(WORDBITS / 8);
  localparam int LW  = $clog2(LINEITEMS);
  localparam int LIW = $clog2(MEMLINES);
  localparam int LFW = ADDRBITS - BO - LW;
  localparam int AW  = LIW + LW;
  localparam int CW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LW-1:0] LAST = LW'(LINEITEMS - 1);
`ifdef MEM_BOUNDS_CHECK_EN
  localparam logic [LFW-1:0] MEMLINES_L = LFW'(MEMLINES);
`endif

  mem_state_t     state;
  logic [CW-1:0]  cnt;
  logic [LW-1:0]  beat;
  logic [LW-1:0]  start_q;
  logic [LIW-1:0] line_q;
  logic           wr_q;
  logic           rearm;
  logic [LFW-1:0] line_full;
  logic [LW-1:0]  addr_off;
  logic [LW-1:0]  off;
  logic           arr_en;
  logic           arr_we;
  logic [AW-1:0]  arr_addr;
  logic           unused_bits;

  assign line_full   = addr[ADDRBITS-1:BO+LW];
  assign addr_off    = addr[BO+LW-1:BO];
  assign unused_bits = ^addr[BO-1:0];

  // Reads run one beat ahead so each fill word is already registered when valid rises.
  always_comb begin
    arr_en = 1'b0;
    arr_we = 1'b0;
    off    = start_q;
    case (state)
      WAIT:  arr_en = (cnt == '0) && !wr_q;
      BURST: begin
        if (wr_q) begin
          off    = start_q + beat;
          arr_en = 1'b1;
          arr_we = 1'b1;
        end else begin
          off    = start_q + beat + LW'(1);
          arr_en = (beat != LAST);
        end
      end
      default: ;
    endcase
  end

  assign arr_addr = {line_q, off};

  mem_array #(
    .WORDBITS(WORDBITS),
    .DEPTH   (MEMLINES * LINEITEMS),
    .AW      (AW)
  ) u_array (
    .clock(clock),
    .reset(reset),
    .en   (arr_en),
    .we   (arr_we),
    .addr (arr_addr),
    .wdata(wdata),
    .rdata(rdata)
  );

  // rearm blocks a new acceptance until request has been seen low after a done pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      beat    <= '0;
      start_q <= '0;
      line_q  <= '0;
      wr_q    <= 1'b0;
      rearm   <= 1'b0;
      valid   <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
      error   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
      error <= 1'b0;
`endif
      if (!request) rearm <= 1'b0;
      case (state)
        IDLE: begin
          if (request && !rearm) begin
            wr_q    <= write;
            start_q <= addr_off;
            line_q  <= LIW'(line_full % LFW'(MEMLINES));
            busy    <= 1'b1;
`ifdef MEM_BOUNDS_CHECK_EN
            if (line_full >= MEMLINES_L) begin
              state <= DONE;
              done  <= 1'b1;
              error <= 1'b1;
              rearm <= 1'b1;
            end else
`endif
            begin
              state <= WAIT;
              cnt   <= CW'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= BURST;
            valid <= 1'b1;
            beat  <= '0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        BURST: begin
          if (beat == LAST) begin
            state <= DONE;
            valid <= 1'b0;
            done  <= 1'b1;
            rearm <= 1'b1;
          end else begin
            beat <= beat + LW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: fill timing, wrap order, held request, reset abort, bounds, zero lines.
module tb_mem_responder;
  logic        clock = 1'b0;
  logic        reset, request, write;
  logic [31:0] addr, wdata, rdata;
  logic        valid, done, busy;
`ifdef MEM_BOUNDS_CHECK_EN
  logic        error;
`endif

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] beats [4];
  int          nbeats, first_v, done_at;

  always #5 clock = ~clock;

  mem_responder #(
    .ADDRBITS(32), .WORDBITS(32), .LINEITEMS(4), .MEMLINES(1024), .LATENCY(4)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .request(request),
    .write  (write),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .valid  (valid),
    .done   (done),
    .busy   (busy)
`ifdef MEM_BOUNDS_CHECK_EN
    ,
    .error  (error)
`endif
  );

  task automatic do_fill(input logic [31:0] a, input bit hold);
    @(negedge clock);
    request = 1'b1; write = 1'b0; addr = a;
    nbeats = 0; first_v = -1; done_at = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (valid) begin
        if (nbeats < 4) beats[nbeats] = rdata;
        if (nbeats == 0) first_v = n;
        nbeats++;
      end
      if (done) begin done_at = n; break; end
    end
    if (!hold) request = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d0, d1, d2, d3);
    logic [31:0] d [4];
    int b;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    @(negedge clock);
    request = 1'b1; write = 1'b1; addr = a;
    b = 0; done_at = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (valid && b < 4) begin wdata = d[b]; b++; end
      if (done) begin done_at = n; break; end
    end
    request = 1'b0; write = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; request = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(negedge clock);
    compared++; if (valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", valid); end
    compared++; if (done !== 1'b0)  begin mismatched++; $display("FAIL reset_done: got %b want 0", done); end
    compared++; if (busy !== 1'b0)  begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
    compared++; if (rdata !== 32'h0) begin mismatched++; $display("FAIL reset_rdata: got %h want 0", rdata); end
`ifdef MEM_BOUNDS_CHECK_EN
    compared++; if (error !== 1'b0) begin mismatched++; $display("FAIL reset_error: got %b want 0", error); end
`endif
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_unwritten;
    do_fill(32'h0000_0070, 1'b0);
    compared++; if (nbeats !== 4) begin mismatched++; $display("FAIL unwr_beats: got %0d want 4", nbeats); end
    for (int k = 0; k < 4; k++) begin
      compared++;
      if (beats[k] !== 32'h0) begin mismatched++; $display("FAIL unwr_word%0d: got %h want 00000000", k, beats[k]); end
    end
  endtask

  task automatic test_fill;
    do_write(32'h0, 32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003);
    compared++; if (done_at !== 9) begin mismatched++; $display("FAIL fill_preset_done: got %0d want 9", done_at); end
    do_fill(32'h0, 1'b0);
    compared++; if (first_v !== 5) begin mismatched++; $display("FAIL fill_first_valid: got %0d want 5", first_v); end
    compared++; if (nbeats !== 4)  begin mismatched++; $display("FAIL fill_beats: got %0d want 4", nbeats); end
    compared++; if (done_at !== 9) begin mismatched++; $display("FAIL fill_done_at: got %0d want 9", done_at); end
    for (int k = 0; k < 4; k++) begin
      compared++;
      if (beats[k] !== 32'h1000_0000 + k) begin
        mismatched++; $display("FAIL fill_word%0d: got %h want %h", k, beats[k], 32'h1000_0000 + k);
      end
    end
    @(negedge clock);
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL fill_done_width: got %b want 0", done); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL fill_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_wrap;
    logic [31:0] exp [4];
    exp[0] = 32'hA000_0002; exp[1] = 32'hA000_0003; exp[2] = 32'hA000_0000; exp[3] = 32'hA000_0001;
    do_write(32'h10, 32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003);
    compared++; if (done_at !== 9) begin mismatched++; $display("FAIL wrap_wb_done: got %0d want 9", done_at); end
    do_fill(32'h18, 1'b0);
    compared++; if (nbeats !== 4) begin mismatched++; $display("FAIL wrap_beats: got %0d want 4", nbeats); end
    for (int k = 0; k < 4; k++) begin
      compared++;
      if (beats[k] !== exp[k]) begin mismatched++; $display("FAIL wrap_beat%0d: got %h want %h", k, beats[k], exp[k]); end
    end
  endtask

  task automatic test_held_request;
    bit got_done;
    do_fill(32'h20, 1'b1);
    compared++; if (done_at !== 9) begin mismatched++; $display("FAIL held_done_at: got %0d want 9", done_at); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      compared++;
      if (busy !== 1'b0 || valid !== 1'b0) begin
        mismatched++; $display("FAIL held_no_restart%0d: busy=%b valid=%b want 0/0", i, busy, valid);
      end
    end
    request = 1'b0;
    @(negedge clock);
    request = 1'b1;
    @(negedge clock);
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL held_restart: busy=%b want 1", busy); end
    got_done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (done) begin got_done = 1'b1; break; end
    end
    request = 1'b0;
    compared++; if (got_done !== 1'b1) begin mismatched++; $display("FAIL held_second_done: got %b want 1", got_done); end
  endtask

  task automatic test_reset_mid_burst;
    int  b;
    bit  hit;
    do_write(32'h30, 32'h5000_0000, 32'h5000_0001, 32'h5000_0002, 32'h5000_0003);
    compared++; if (done_at !== 9) begin mismatched++; $display("FAIL rst_preset_done: got %0d want 9", done_at); end
    @(negedge clock);
    request = 1'b1; write = 1'b1; addr = 32'h30;
    b = 0; hit = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (valid) begin
        if (b == 0) wdata = 32'hEE00_0000;
        else begin
          wdata = 32'hEE00_0001; reset = 1'b1; hit = 1'b1;
          #1;
          compared++; if (valid !== 1'b0) begin mismatched++; $display("FAIL rst_valid_now: got %b want 0", valid); end
          compared++; if (busy !== 1'b0)  begin mismatched++; $display("FAIL rst_busy_now: got %b want 0", busy); end
          break;
        end
        b++;
      end
    end
    compared++; if (hit !== 1'b1) begin mismatched++; $display("FAIL rst_reached_beat2: got %b want 1", hit); end
    request = 1'b0; write = 1'b0;
    @(negedge clock);
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL rst_no_done_a: got %b want 0", done); end
    reset = 1'b0;
    @(negedge clock);
    compared++; if (done !== 1'b0 || busy !== 1'b0) begin
      mismatched++; $display("FAIL rst_no_done_b: done=%b busy=%b want 0/0", done, busy);
    end
    do_fill(32'h30, 1'b0);
    compared++; if (beats[0] !== 32'hEE00_0000) begin mismatched++; $display("FAIL rst_kept_w0: got %h want ee000000", beats[0]); end
    for (int k = 1; k < 4; k++) begin
      compared++;
      if (beats[k] !== 32'h5000_0000 + k) begin
        mismatched++; $display("FAIL rst_untouched_w%0d: got %h want %h", k, beats[k], 32'h5000_0000 + k);
      end
    end
  endtask

`ifdef MEM_BOUNDS_CHECK_EN
  task automatic test_bounds;
    @(negedge clock);
    request = 1'b1; write = 1'b0; addr = 32'h0000_4000;
    @(negedge clock);
    compared++; if (done !== 1'b1)  begin mismatched++; $display("FAIL bnd_done: got %b want 1", done); end
    compared++; if (error !== 1'b1) begin mismatched++; $display("FAIL bnd_error: got %b want 1", error); end
    compared++; if (valid !== 1'b0) begin mismatched++; $display("FAIL bnd_valid: got %b want 0", valid); end
    request = 1'b0;
    @(negedge clock);
    compared++; if (done !== 1'b0 || error !== 1'b0 || busy !== 1'b0) begin
      mismatched++; $display("FAIL bnd_after: done=%b error=%b busy=%b want 0/0/0", done, error, busy);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_unwritten;
    test_fill;
    test_wrap;
    test_held_request;
    test_reset_mid_burst;
`ifdef MEM_BOUNDS_CHECK_EN
    test_bounds;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
